// File: rtl/hazard_ctrl_pkg.sv
// Shared header for the hazard controller: MUL sequencer state encodings,
// the zero-register index and the default MUL latency.
package hazard_ctrl_pkg;

    typedef enum logic [0:0] {
        HZ_ST_RUN      = 1'b0,
        HZ_ST_MUL_WAIT = 1'b1
    } hzState_e;

    // X31 reads as zero, so it can never carry a load-use dependency.
    localparam logic [4:0] XZR = 5'd31;

    localparam int HZ_MUL_CYCLES_DEF = 4;

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID/EX hazard-information bundle and pipeline control outputs.
// Optional statistics ports appear when HAZARD_STATS_EN is defined.
interface hazard_ctrl_if;

    logic [4:0] id_rn;
    logic [4:0] id_rm;
    logic       id_use_rm;
    logic       ex_MemRead;
    logic [4:0] ex_rd;
    logic       ex_mul_start;
    logic       ex_br_taken;

    logic       PCWrite;
    logic       IFIDWrite;
    logic       IDEXWrite;
    logic       IDEXBubble;
    logic       IFIDFlush;
    logic       IDEXFlush;
    logic       EXMEMBubble;
    logic       ExHold;
    logic       busy;
`ifdef HAZARD_STATS_EN
    logic [31:0] stat_stall;
    logic [31:0] stat_flush;
    logic [31:0] stat_mul;
`endif

    // Pipeline/decoder side: supplies hazard fields, consumes controls.
    modport master (
        output id_rn, id_rm, id_use_rm, ex_MemRead, ex_rd, ex_mul_start, ex_br_taken,
        input  PCWrite, IFIDWrite, IDEXWrite, IDEXBubble, IFIDFlush, IDEXFlush,
               EXMEMBubble, ExHold, busy
`ifdef HAZARD_STATS_EN
        , input stat_stall, stat_flush, stat_mul
`endif
    );

    // Hazard controller side.
    modport slave (
        input  id_rn, id_rm, id_use_rm, ex_MemRead, ex_rd, ex_mul_start, ex_br_taken,
        output PCWrite, IFIDWrite, IDEXWrite, IDEXBubble, IFIDFlush, IDEXFlush,
               EXMEMBubble, ExHold, busy
`ifdef HAZARD_STATS_EN
        , output stat_stall, stat_flush, stat_mul
`endif
    );

endinterface

// File: rtl/hazard_ctrl_mul_seq.sv
// MUL sequencer: holds EX for MUL_CYCLES-1 cycles using a countdown counter.
// The first hold cycle is raised combinationally while still in RUN.
module mul_seq
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = HZ_MUL_CYCLES_DEF,
    parameter int CNT_W      = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mulStart,
    output logic ExHold,
    output logic busy,
    output logic mulEnter
);

    localparam bit               MULTI    = (MUL_CYCLES >= 2);
    localparam logic [CNT_W-1:0] CNT_LOAD = MULTI ? CNT_W'(MUL_CYCLES - 2) : '0;

    hzState_e         state, stateNxt;
    logic [CNT_W-1:0] cnt, cntNxt;

    // State and countdown registers; reset drops straight back to RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HZ_ST_RUN;
            cnt   <= '0;
        end else begin
            state <= stateNxt;
            cnt   <= cntNxt;
        end
    end

    // Next state, counter update and hold output.
    always_comb begin
        stateNxt = state;
        cntNxt   = cnt;
        ExHold   = 1'b0;
        mulEnter = 1'b0;
        case (state)
            HZ_ST_RUN: begin
                if (mulStart && MULTI) begin
                    ExHold   = 1'b1;
                    mulEnter = 1'b1;
                    stateNxt = HZ_ST_MUL_WAIT;
                    cntNxt   = CNT_LOAD;
                end
            end
            HZ_ST_MUL_WAIT: begin
                // mulStart is ignored here; at cnt==0 the MUL leaves EX.
                if (cnt != '0) begin
                    ExHold = 1'b1;
                    cntNxt = cnt - CNT_W'(1);
                end else begin
                    stateNxt = HZ_ST_RUN;
                end
            end
            default: stateNxt = HZ_ST_RUN;
        endcase
    end

    assign busy = (state == HZ_ST_MUL_WAIT);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage LEGv8 pipeline.
// Priority: MUL hold > taken-branch flush > load-use stall.
// Define HAZARD_STATS_EN to add saturating stall/flush/MUL counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = HZ_MUL_CYCLES_DEF,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    hazard_ctrl_if.slave hz
);

    logic exHold, busy, mulEnter, luh, brTaken;
    logic pcWrite, ifidWrite, idexWrite, idexBubble, ifidFlush, idexFlush, exmemBubble;

    mul_seq #(
        .MUL_CYCLES(MUL_CYCLES),
        .CNT_W     (CNT_W)
    ) u_mulSeq (
        .clk     (clk),
        .rst_n   (rst_n),
        .mulStart(hz.ex_mul_start),
        .ExHold  (exHold),
        .busy    (busy),
        .mulEnter(mulEnter)
    );

    assign brTaken = hz.ex_br_taken;
    assign luh = hz.ex_MemRead & (hz.ex_rd != XZR) &
                 ((hz.ex_rd == hz.id_rn) | (hz.id_use_rm & (hz.ex_rd == hz.id_rm)));

    // Priority resolution of hold, flush and load-use stall.
    always_comb begin
        pcWrite     = 1'b1;
        ifidWrite   = 1'b1;
        idexWrite   = 1'b1;
        idexBubble  = 1'b0;
        ifidFlush   = 1'b0;
        idexFlush   = 1'b0;
        exmemBubble = 1'b0;
        if (exHold) begin
            pcWrite     = 1'b0;
            ifidWrite   = 1'b0;
            idexWrite   = 1'b0;
            exmemBubble = 1'b1;
        end else if (brTaken) begin
            ifidFlush = 1'b1;
            idexFlush = 1'b1;
        end else if (luh) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexBubble = 1'b1;
        end
    end

    assign hz.PCWrite     = pcWrite;
    assign hz.IFIDWrite   = ifidWrite;
    assign hz.IDEXWrite   = idexWrite;
    assign hz.IDEXBubble  = idexBubble;
    assign hz.IFIDFlush   = ifidFlush;
    assign hz.IDEXFlush   = idexFlush;
    assign hz.EXMEMBubble = exmemBubble;
    assign hz.ExHold      = exHold;
    assign hz.busy        = busy;

`ifdef HAZARD_STATS_EN
    logic [31:0] statStall, statFlush, statMul;

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            statStall <= '0;
            statFlush <= '0;
            statMul   <= '0;
        end else begin
            if (idexBubble && (statStall != '1)) statStall <= statStall + 32'd1;
            if (ifidFlush  && (statFlush != '1)) statFlush <= statFlush + 32'd1;
            if (mulEnter   && (statMul   != '1)) statMul   <= statMul   + 32'd1;
        end
    end

    assign hz.stat_stall = statStall;
    assign hz.stat_flush = statFlush;
    assign hz.stat_mul   = statMul;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MUL_CYCLES=4): vector table for the
// combinational hazard/priority logic plus hand sequences for MUL and reset.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nPass = 0;
    int   nTotal = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if hzIf ();

    hazard_ctrl #(
        .MUL_CYCLES(4),
        .CNT_W     (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .hz   (hzIf.slave)
    );

    // Output order: PCWrite IFIDWrite IDEXWrite IDEXBubble IFIDFlush IDEXFlush EXMEMBubble ExHold busy
    localparam logic [8:0] O_IDLE  = 9'b111_000_000;
    localparam logic [8:0] O_STALL = 9'b001_100_000;
    localparam logic [8:0] O_FLUSH = 9'b111_011_000;
    localparam logic [8:0] O_HOLD0 = 9'b000_000_110;
    localparam logic [8:0] O_HOLDW = 9'b000_000_111;
    localparam logic [8:0] O_REL   = 9'b111_000_001;
    localparam logic [8:0] O_RELBR = 9'b111_011_001;

    typedef struct {
        string      name;
        logic [4:0] rn, rm, rd;
        logic       useRm, memRead, br;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [8:0] outs();
        return {hzIf.PCWrite, hzIf.IFIDWrite, hzIf.IDEXWrite, hzIf.IDEXBubble,
                hzIf.IFIDFlush, hzIf.IDEXFlush, hzIf.EXMEMBubble, hzIf.ExHold, hzIf.busy};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nTotal++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic setIn(input logic [4:0] rn, rm, rd, input logic useRm, memRead, br, mul);
        hzIf.id_rn        = rn;
        hzIf.id_rm        = rm;
        hzIf.ex_rd        = rd;
        hzIf.id_use_rm    = useRm;
        hzIf.ex_MemRead   = memRead;
        hzIf.ex_br_taken  = br;
        hzIf.ex_mul_start = mul;
    endtask

    // One full 4-cycle MUL; relExp is the expected vector on the release cycle.
    task automatic doMul(input string nm, input logic keepStart, input logic [8:0] relExp);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            hzIf.ex_mul_start = (k < 3) ? 1'b1 : keepStart;
            #1;
            chk($sformatf("%s_c%0d", nm, k), 32'(outs()),
                32'((k == 0) ? O_HOLD0 : (k < 3) ? O_HOLDW : relExp));
        end
    endtask

    initial begin
        vecs[0] = '{"idle",      5'd1,  5'd2, 5'd3,  1'b1, 1'b0, 1'b0, O_IDLE};
        vecs[1] = '{"luh_rn",    5'd5,  5'd2, 5'd5,  1'b0, 1'b1, 1'b0, O_STALL};
        vecs[2] = '{"xzr_nostl", 5'd31, 5'd2, 5'd31, 1'b1, 1'b1, 1'b0, O_IDLE};
        vecs[3] = '{"rm_unused", 5'd3,  5'd5, 5'd5,  1'b0, 1'b1, 1'b0, O_IDLE};
        vecs[4] = '{"luh_rm",    5'd3,  5'd5, 5'd5,  1'b1, 1'b1, 1'b0, O_STALL};
        vecs[5] = '{"no_load",   5'd5,  5'd5, 5'd5,  1'b1, 1'b0, 1'b0, O_IDLE};
        vecs[6] = '{"br_only",   5'd1,  5'd2, 5'd3,  1'b0, 1'b0, 1'b1, O_FLUSH};
        vecs[7] = '{"br_luh",    5'd5,  5'd2, 5'd5,  1'b0, 1'b1, 1'b1, O_FLUSH};
        vecs[8] = '{"luh_x0",    5'd0,  5'd2, 5'd0,  1'b0, 1'b1, 1'b0, O_STALL};

        // Reset with idle inputs, release mid-cycle.
        setIn(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        #12;
        chk("rst_outs", 32'(outs()), 32'(O_IDLE));
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1 chk("rel_busy", 32'(hzIf.busy), 32'd0);
        @(posedge clk);
        #1 chk("rel_idle", 32'(outs()), 32'(O_IDLE));

        // Combinational vector table.
        foreach (vecs[i]) begin
            @(negedge clk);
            setIn(vecs[i].rn, vecs[i].rm, vecs[i].rd, vecs[i].useRm, vecs[i].memRead, vecs[i].br, 1'b0);
            #1 chk(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
        end

        // MUL with idle inputs, then a back-to-back MUL with luh+branch pending.
        @(negedge clk);
        setIn(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        doMul("mul1", 1'b0, O_REL);
        @(negedge clk);
        setIn(5'd5, 5'd2, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0);
        doMul("mul2", 1'b1, O_RELBR);
        doMul("mul3", 1'b0, O_RELBR);
        @(negedge clk);
        setIn(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 chk("mul_done", 32'(outs()), 32'(O_IDLE));

        // Reset on the 2nd hold cycle of a MUL.
        @(negedge clk);
        hzIf.ex_mul_start = 1'b1;
        @(negedge clk);
        #1 chk("mid_hold", 32'(outs()), 32'(O_HOLDW));
        hzIf.ex_mul_start = 1'b0;
        rst_n = 1'b0;
        #1 chk("mid_rst", 32'(outs()), 32'(O_IDLE));
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1 chk("post_rst", 32'(outs()), 32'(O_IDLE));
        doMul("mul4", 1'b0, O_REL);

`ifdef HAZARD_STATS_EN
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk("stat_rst", 32'(hzIf.stat_stall | hzIf.stat_flush | hzIf.stat_mul), 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk); setIn(5'd5, 5'd2, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk); setIn(5'd4, 5'd4, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk); setIn(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk); setIn(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        doMul("smul", 1'b0, O_REL);
        @(negedge clk);
        chk("stat_stall", hzIf.stat_stall, 32'd2);
        chk("stat_flush", hzIf.stat_flush, 32'd1);
        chk("stat_mul",   hzIf.stat_mul,   32'd1);
`endif

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
